// File: rtl/ps2_cmd_tx.sv
// ps2_cmd_tx: bus-mapped PS/2 host-to-device command transmitter.
// A byte written to BASE_ADDR is sent to the device using the PS/2
// request-to-send sequence; completion raises a level interrupt and a
// status byte is readable at BASE_ADDR+1.
//
// Handshakes:
//  - Command write: a single-cycle strobe (BUS_WE=1, BUS_ADDR=BASE_ADDR). It
//    is accepted only in IDLE; any write seen while busy is dropped and
//    recorded in the sticky overrun flag. There is no back-pressure signal.
//  - Interrupt: BUS_INTERRUPT_RAISE is a level that stays high until
//    BUS_INTERRUPT_ACK is sampled high. It drops on the following cycle,
//    unless a new completion lands on that same edge, in which case it stays high.
module ps2_cmd_tx #(
  parameter logic [7:0] BASE_ADDR      = 8'hA4,
  parameter int         INHIBIT_CYCLES = 5000,
  parameter int         TIMEOUT_CYCLES = 750000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA,
  output logic [2:0] o_dbg_state
);

  localparam logic [7:0] STATUS_ADDR = BASE_ADDR + 8'd1;
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_START   = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_idx, w_idx_nxt;
  logic             r_clk_low, w_clk_low_nxt;
  logic             r_data_low, w_data_low_nxt;
  logic             r_ack_seen, w_ack_seen_nxt;
  logic [7:0]       r_byte;
  logic             r_parity;
  logic             r_clk_s1, r_clk_s2, r_clk_s3;
  logic             r_data_s1, r_data_s2;
  logic             r_ack_err, r_timeout, r_overrun;
  logic             r_raise;
  logic [7:0]       r_status;
  logic             w_wr_cmd, w_accept, w_fall;
  logic             w_done, w_tmo, w_ack_bad;

  assign w_wr_cmd = BUS_WE && (BUS_ADDR == BASE_ADDR);
  assign w_accept = w_wr_cmd && (r_state == S_IDLE);
  assign w_fall   = r_clk_s3 && !r_clk_s2;

  // Open-collector outputs: only ever pull low or release.
  assign PS2_CLK  = r_clk_low  ? 1'b0 : 1'bz;
  assign PS2_DATA = r_data_low ? 1'b0 : 1'bz;
  assign BUS_DATA = (BUS_ADDR == STATUS_ADDR && !BUS_WE) ? r_status : 8'bz;
  assign BUS_INTERRUPT_RAISE = r_raise;
  assign o_dbg_state = r_state;

  // Bring the device-driven lines into the CLK domain; s3 gives the edge history.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_clk_s3  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_clk_s1  <= PS2_CLK;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
      r_data_s1 <= PS2_DATA;
      r_data_s2 <= r_data_s1;
    end
  end

  // FSM state, counters and registered line drives.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_ack_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_clk_low  <= w_clk_low_nxt;
      r_data_low <= w_data_low_nxt;
      r_ack_seen <= w_ack_seen_nxt;
    end
  end

  // Next-state logic: inhibit, start bit, shift on device falls, ack, timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_data_low_nxt = r_data_low;
    w_ack_seen_nxt = r_ack_seen;
    w_done         = 1'b0;
    w_tmo          = 1'b0;
    w_ack_bad      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_data_low_nxt = 1'b0;
        if (w_wr_cmd) begin
          w_state_nxt = S_INHIBIT;
          w_cnt_nxt   = '0;
        end
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_state_nxt    = S_START;
          w_cnt_nxt      = '0;
          w_data_low_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_START: begin
        // Start bit already low; releasing the clock hands timing to the device.
        w_state_nxt = S_SEND;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
      S_SEND: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == TO_LAST) begin
          w_tmo          = 1'b1;
          w_state_nxt    = S_IDLE;
          w_data_low_nxt = 1'b0;
        end else if (w_fall) begin
          w_idx_nxt = r_idx + 4'd1;
          if (r_idx < 4'd8) begin
            w_data_low_nxt = ~r_byte[r_idx[2:0]];
          end else if (r_idx == 4'd8) begin
            w_data_low_nxt = ~r_parity;
          end else begin
            w_data_low_nxt = 1'b0;
            w_ack_seen_nxt = 1'b0;
            w_state_nxt    = S_ACK;
          end
        end
      end
      S_ACK: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_ack_seen && r_clk_s2 && r_data_s2) begin
          w_state_nxt = S_DONE;
        end else if (r_cnt == TO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!r_ack_seen && w_fall) begin
          w_ack_seen_nxt = 1'b1;
          w_ack_bad      = r_data_s2;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_data_low_nxt = 1'b0;
      end
    endcase
    w_clk_low_nxt = (w_state_nxt == S_INHIBIT) || (w_state_nxt == S_START);
  end

  // Command latch, sticky flags, interrupt level and registered status byte.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_byte    <= '0;
      r_parity  <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      r_raise   <= 1'b0;
      r_status  <= '0;
    end else begin
      if (w_accept) begin
        r_byte    <= BUS_DATA;
        r_parity  <= ~^BUS_DATA;
        r_ack_err <= 1'b0;
        r_timeout <= 1'b0;
        r_overrun <= 1'b0;
      end else begin
        if (w_wr_cmd)  r_overrun <= 1'b1;
        if (w_ack_bad) r_ack_err <= 1'b1;
        if (w_tmo)     r_timeout <= 1'b1;
      end
      if (w_done || w_tmo)        r_raise <= 1'b1;
      else if (BUS_INTERRUPT_ACK) r_raise <= 1'b0;
      r_status <= {4'b0000, r_overrun, r_timeout, r_ack_err, (r_state != S_IDLE)};
    end
  end

endmodule
